// File: rtl/imem_pkg.sv
// imem_pkg: shared FSM states, default geometry and fetch NOP for the instruction memory load arbiter.
package imem_pkg;
  typedef enum logic [1:0] {BOOT, LOAD, FLUSH, RUN} state_e;
  localparam int IMEM_DEPTH = 256;
  localparam int IMEM_WIDTH = 32;
  localparam logic [31:0] NOP = 32'h0;
endpackage

// File: rtl/imem_load_arb_if.sv
// imem_load_arb_if: loader, fetch, memory and status signals of the load arbiter.
// IMEM_LOAD_CHECKSUM_EN adds the ld_csum session checksum output.
interface imem_load_arb_if import imem_pkg::*; #(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int WIDTH = IMEM_WIDTH
);
  localparam int AW = $clog2(DEPTH);
  logic             ld_start;
  logic             ld_valid;
  logic             ld_ready;
  logic [AW-1:0]    ld_addr;
  logic [WIDTH-1:0] ld_data;
  logic             ld_done;
  logic             if_req;
  logic [31:0]      if_pc;
  logic [WIDTH-1:0] if_inst;
  logic             if_valid;
  logic             cpu_stall;
  logic             fetch_err;
  logic             mem_en;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;
  logic [AW:0]      word_cnt;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [WIDTH-1:0] ld_csum;
`endif
  modport slave (
`ifdef IMEM_LOAD_CHECKSUM_EN
    output ld_csum,
`endif
    input  ld_start, ld_valid, ld_addr, ld_data, ld_done, if_req, if_pc, mem_rdata,
    output ld_ready, if_inst, if_valid, cpu_stall, fetch_err, mem_en, mem_we, mem_addr, mem_wdata, word_cnt
  );
  modport master (
`ifdef IMEM_LOAD_CHECKSUM_EN
    input  ld_csum,
`endif
    output ld_start, ld_valid, ld_addr, ld_data, ld_done, if_req, if_pc, mem_rdata,
    input  ld_ready, if_inst, if_valid, cpu_stall, fetch_err, mem_en, mem_we, mem_addr, mem_wdata, word_cnt
  );
endinterface

// File: rtl/imem_fetch_chk.sv
// imem_fetch_chk: word-aligned, in-range pc check and word index extraction.
module imem_fetch_chk #(
  parameter int DEPTH = 256
) (
  input  logic [31:0]              pc_i,
  output logic                     legal_o,
  output logic [$clog2(DEPTH)-1:0] idx_o
);
  assign legal_o = pc_i[1:0] == 2'b00 && pc_i[31:2] < 30'(DEPTH);
  assign idx_o   = pc_i[$clog2(DEPTH)+1:2];
endmodule

// File: rtl/imem_load_arb.sv
// imem_load_arb: arbitrates a single-port instruction memory between a loader (LOAD) and IF fetch (RUN).
// IMEM_LOAD_CHECKSUM_EN adds an XOR checksum of the words accepted in the current session.
module imem_load_arb import imem_pkg::*; #(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int WIDTH = IMEM_WIDTH
) (
  input logic            clk,
  input logic            reset,
  imem_load_arb_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  state_e        state_q, state_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          rd_q, rd_d, err_q, err_d, ferr_q, ferr_d;
  logic          legal, load, run, wr, fetch, enter_load;
  logic [AW-1:0] idx;
  imem_fetch_chk #(.DEPTH(DEPTH)) u_chk (.pc_i(bus.if_pc), .legal_o(legal), .idx_o(idx));
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = bus.ld_start ? LOAD : BOOT;
      LOAD:    state_d = bus.ld_done ? RUN : LOAD;
      RUN:     state_d = bus.ld_start ? FLUSH : RUN;
      default: state_d = LOAD;
    endcase
  end
  assign load       = state_q == LOAD;
  assign run        = state_q == RUN;
  assign wr         = load & bus.ld_valid;
  assign fetch      = run & bus.if_req & legal;
  assign enter_load = state_d == LOAD && !load;
  always_comb begin
    cnt_d  = enter_load ? '0 : (wr && cnt_q != (AW+1)'(DEPTH)) ? cnt_q + 1'b1 : cnt_q;
    rd_d   = fetch;
    err_d  = run & bus.if_req & ~legal;
    ferr_d = ferr_q | err_d;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BOOT;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      ferr_q  <= ferr_d;
    end
  end
  assign bus.ld_ready  = load;
  assign bus.cpu_stall = ~run;
  assign bus.mem_en    = wr | fetch;
  assign bus.mem_we    = wr;
  assign bus.mem_addr  = wr ? bus.ld_addr : fetch ? idx : '0;
  assign bus.mem_wdata = wr ? bus.ld_data : '0;
  // a read issued in the last RUN cycle returns during FLUSH and is dropped here
  assign bus.if_valid  = run & (rd_q | err_q);
  assign bus.if_inst   = (run & rd_q) ? bus.mem_rdata : WIDTH'(NOP);
  assign bus.fetch_err = ferr_q;
  assign bus.word_cnt  = cnt_q;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [WIDTH-1:0] csum_q, csum_d;
  assign csum_d = enter_load ? '0 : wr ? csum_q ^ bus.ld_data : csum_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) csum_q <= '0;
    else       csum_q <= csum_d;
  end
  assign bus.ld_csum = csum_q;
`endif
endmodule

// File: tb/tb_imem_load_arb.sv
// tb_imem_load_arb: table-driven cycle vectors plus reset, saturation and checksum sequences.
module tb_imem_load_arb;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  imem_load_arb_if #(.DEPTH(256), .WIDTH(32)) bus ();
  imem_load_arb #(.DEPTH(256), .WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  logic [31:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = 32'hA5A50000 | 32'(i);
  always @(posedge clk) if (bus.mem_en) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    else bus.mem_rdata <= mem[bus.mem_addr];
  end
  typedef struct {
    logic st, lv, ld, rq;
    logic [7:0] la;
    logic [31:0] lw, pc;
    logic [86:0] exp;
  } vec_t;
  vec_t v[$];
  int errs = 0, checks = 0;
  function automatic logic [86:0] pk(logic rdy, stl, en, we, logic [7:0] ma, logic [31:0] wd,
                                     logic iv, logic [31:0] ins, logic fe, logic [8:0] cnt);
    return {rdy, stl, en, we, ma, wd, iv, ins, fe, cnt};
  endfunction
  function automatic logic [86:0] obs();
    return {bus.ld_ready, bus.cpu_stall, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata,
            bus.if_valid, bus.if_inst, bus.fetch_err, bus.word_cnt};
  endfunction
  task automatic add(logic st, lv, ld, logic [7:0] la, logic [31:0] lw, logic rq, logic [31:0] pc,
                     logic [86:0] exp);
    vec_t t;
    t.st = st; t.lv = lv; t.ld = ld; t.la = la; t.lw = lw; t.rq = rq; t.pc = pc; t.exp = exp;
    v.push_back(t);
  endtask
  task automatic chk(string nm, logic [86:0] act, logic [86:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask
  task automatic drive(logic st, lv, ld, logic [7:0] la, logic [31:0] lw, logic rq, logic [31:0] pc);
    bus.ld_start = st; bus.ld_valid = lv; bus.ld_done = ld; bus.ld_addr = la;
    bus.ld_data = lw; bus.if_req = rq; bus.if_pc = pc;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,                      pk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    add(1, 1, 0, 5, 32'h55, 1, 0,                 pk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    add(0, 1, 0, 0, 32'h8C010000, 0, 0,           pk(1, 1, 1, 1, 0, 32'h8C010000, 0, 0, 0, 0));
    add(0, 1, 0, 1, 32'h20020005, 0, 0,           pk(1, 1, 1, 1, 1, 32'h20020005, 0, 0, 0, 1));
    add(1, 1, 0, 2, 32'h00221820, 0, 0,           pk(1, 1, 1, 1, 2, 32'h00221820, 0, 0, 0, 2));
    add(0, 0, 0, 0, 0, 0, 0,                      pk(1, 1, 0, 0, 0, 0, 0, 0, 0, 3));
    add(0, 1, 1, 3, 32'hAC030004, 0, 0,           pk(1, 1, 1, 1, 3, 32'hAC030004, 0, 0, 0, 3));
    add(0, 1, 1, 9, 32'h77, 1, 0,                 pk(0, 0, 1, 0, 0, 0, 0, 0, 0, 4));
    add(0, 0, 0, 0, 0, 1, 4,                      pk(0, 0, 1, 0, 1, 0, 1, 32'h8C010000, 0, 4));
    add(0, 0, 0, 0, 0, 1, 8,                      pk(0, 0, 1, 0, 2, 0, 1, 32'h20020005, 0, 4));
    add(0, 0, 0, 0, 0, 1, 12,                     pk(0, 0, 1, 0, 3, 0, 1, 32'h00221820, 0, 4));
    add(0, 0, 0, 0, 0, 0, 0,                      pk(0, 0, 0, 0, 0, 0, 1, 32'hAC030004, 0, 4));
    add(0, 0, 0, 0, 0, 0, 0,                      pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4));
    add(0, 0, 0, 0, 0, 1, 32'h402,                pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4));
    add(0, 0, 0, 0, 0, 1, 32'h400,                pk(0, 0, 0, 0, 0, 0, 1, 0, 1, 4));
    add(0, 0, 0, 0, 0, 1, 32'h3FC,                pk(0, 0, 1, 0, 8'hFF, 0, 1, 0, 1, 4));
    add(0, 0, 0, 0, 0, 0, 0,                      pk(0, 0, 0, 0, 0, 0, 1, 32'hA5A500FF, 1, 4));
    add(1, 0, 0, 0, 0, 1, 0,                      pk(0, 0, 1, 0, 0, 0, 0, 0, 1, 4));
    add(0, 0, 0, 0, 0, 1, 4,                      pk(0, 1, 0, 0, 0, 0, 0, 0, 1, 4));
    add(0, 0, 0, 0, 0, 0, 0,                      pk(1, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    @(negedge clk);
    chk("reset_state", obs(), pk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    reset = 1'b0;
    foreach (v[i]) begin
      tick();
      drive(v[i].st, v[i].lv, v[i].ld, v[i].la, v[i].lw, v[i].rq, v[i].pc);
      @(negedge clk);
      chk($sformatf("vec%0d", i), obs(), v[i].exp);
    end
    chk("mem0", mem[0], 32'h8C010000);
    chk("mem1", mem[1], 32'h20020005);
    chk("mem2", mem[2], 32'h00221820);
    chk("mem3", mem[3], 32'hAC030004);
    tick(); drive(0, 1, 0, 0, 32'h11111111, 0, 0);
    tick(); drive(0, 1, 0, 1, 32'h22222222, 0, 0);
    tick(); drive(0, 1, 0, 2, 32'h33333333, 1, 0);
    #2;
    chk("pre_reset_cnt", obs(), pk(1, 1, 1, 1, 2, 32'h33333333, 0, 0, 1, 2));
    reset = 1'b1;
    #1;
    chk("async_reset", obs(), pk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    chk("keep_mem0", mem[0], 32'h11111111);
    chk("keep_mem1", mem[1], 32'h22222222);
    chk("keep_mem2", mem[2], 32'h00221820);
    drive(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    tick(); drive(1, 0, 0, 0, 0, 0, 0);
    tick(); drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 257; i++) begin
      drive(0, 1, 0, 8'(i), 32'(i), 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("cnt_saturate", obs(), pk(1, 1, 0, 0, 0, 0, 0, 0, 0, 9'd256));
    chk("sat_mem255", mem[255], 32'd255);
    drive(0, 0, 1, 0, 0, 0, 0);
    tick(); drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("run_after_sat", obs(), pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 9'd256));
`ifdef IMEM_LOAD_CHECKSUM_EN
    begin
      logic [31:0] w [3];
      w[0] = 32'h0000FFFF; w[1] = 32'hFFFF0000; w[2] = 32'h12345678;
      chk("csum_prev", bus.ld_csum, 32'h100);
      tick(); drive(1, 0, 0, 0, 0, 0, 0);
      tick(); drive(0, 0, 0, 0, 0, 0, 0);
      tick();
      @(negedge clk);
      chk("csum_clear", bus.ld_csum, 32'h0);
      for (int k = 0; k < 3; k++) begin
        drive(0, 1, k == 2, 8'(k), w[k], 0, 0);
        tick();
      end
      drive(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("csum_run", {bus.cpu_stall, bus.word_cnt, bus.ld_csum}, {1'b0, 9'd3, 32'hEDCBA987});
    end
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/imem_load_arb.md
IMEM_LOAD_ARB -- requirements
Module: imem_load_arb

Interface
REQ-001 Parameter DEPTH, 256, number of instruction words; address index width AW = clog2(DEPTH).
REQ-002 Parameter WIDTH, 32, instruction word width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 ld_start  in  1  loader requests (re)load session.
REQ-006 ld_valid  in  1  loader write word valid.
REQ-007 ld_ready  out  1  controller accepts loader word.
REQ-008 ld_addr  in  AW  loader word index.
REQ-009 ld_data  in  WIDTH  loader word.
REQ-010 ld_done  in  1  loader ends session.
REQ-011 if_req  in  1  fetch request from pipeline IF stage.
REQ-012 if_pc  in  32  byte address of fetch.
REQ-013 if_inst  out  WIDTH  fetched instruction.
REQ-014 if_valid  out  1  if_inst valid this cycle.
REQ-015 cpu_stall  out  1  holds PC/pipeline while not RUN.
REQ-016 fetch_err  out  1  sticky misaligned/out-of-range fetch flag.
REQ-017 mem_en, mem_we  out  1 each  memory enable/write enable.
REQ-018 mem_addr  out  AW; mem_wdata  out  WIDTH; mem_rdata  in  WIDTH (synchronous read, 1-cycle latency).
REQ-019 word_cnt  out  AW+1  words written in current/last session.

Function
REQ-020 States: BOOT, LOAD, FLUSH, RUN; single-port memory owned by loader in LOAD, by fetch in RUN, by neither in BOOT/FLUSH.
REQ-021 BOOT: cpu_stall=1, ld_ready=0; ld_start -> LOAD next cycle.
REQ-022 LOAD: ld_ready=1, cpu_stall=1; ld_valid -> mem_en=1, mem_we=1, mem_addr=ld_addr, mem_wdata=ld_data same cycle, word_cnt+1.
REQ-023 word_cnt saturates at DEPTH; cleared on LOAD entry.
REQ-024 LOAD: ld_done -> RUN next cycle; ld_valid with ld_done in same cycle: word written first, then RUN.
REQ-025 RUN: cpu_stall=0, ld_ready=0; if_req with legal pc -> mem_en=1, mem_we=0, mem_addr=if_pc[AW+1:2]; if_valid=1 and if_inst=mem_rdata exactly one cycle later.
REQ-026 Legal pc: if_pc[1:0]==0 and if_pc[31:2] < DEPTH.
REQ-027 Illegal pc with if_req: no memory access; next cycle if_valid=1, if_inst=0 (NOP), fetch_err set and held until reset.
REQ-028 Back-to-back if_req each cycle yields one if_valid per cycle, throughput 1.
REQ-029 RUN: ld_start -> FLUSH (cpu_stall=1 same cycle as FLUSH); any read issued in last RUN cycle is discarded (if_valid=0 in FLUSH); FLUSH -> LOAD after one cycle.
REQ-030 ld_start in LOAD ignored; ld_valid/ld_done outside LOAD ignored.
REQ-031 if_req while cpu_stall=1 ignored (no access, no if_valid).

Reset
REQ-032 reset asserted at any time, including mid-LOAD or with read in flight: state=BOOT, cpu_stall=1, ld_ready=0, if_valid=0, if_inst=0, fetch_err=0, word_cnt=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-033 Memory contents not cleared by reset; partial loads remain.

Configuration
REQ-034 Macro IMEM_LOAD_CHECKSUM_EN defined: output ld_csum (WIDTH) = XOR of all words accepted in current session, cleared on LOAD entry and reset, valid in RUN.
REQ-035 Macro undefined: no ld_csum port, no checksum logic.

Structure
REQ-036 Shared package imem_pkg: state enum (BOOT, LOAD, FLUSH, RUN), DEPTH/WIDTH defaults, NOP constant 32'h0.
REQ-037 One sub-module natural: imem_fetch_chk (pc legality check and index extraction); FSM, counters and muxing in top.

Verification
REQ-038 Reset, ld_start, write words 0..3 = 8C010000,20020005,00221820,AC030004, ld_done -> word_cnt=4, RUN, cpu_stall=0; memory holds values.
REQ-039 RUN, if_req with pc=0,4,8,12 on consecutive cycles -> if_valid each following cycle, if_inst=8C010000,20020005,00221820,AC030004.
REQ-040 if_pc=0x402 then if_pc=0x400 (DEPTH=256) -> if_inst=0 both, fetch_err=1, mem_en=0 both cycles.
REQ-041 ld_start in RUN with if_req at pc=0 same cycle -> FLUSH, no if_valid next cycle, LOAD following, word_cnt=0.
REQ-042 Reset asserted mid-LOAD after 2 words -> all outputs at reset values asynchronously, state BOOT, words 0..1 retained.
REQ-043 IMEM_LOAD_CHECKSUM_EN defined, load 0000FFFF, FFFF0000, 12345678 -> ld_csum=EDCBA987 in RUN.
